i2c_target: RTL and testbench
=============================

# i2c_target

Single-address I2C target (slave) that sits on the SDA/SCL bus downstream of the team's single-master I2C controller. It oversamples the bus with its own system clock, detects START/STOP, matches a 7-bit address, and moves data bytes in both directions. Received write bytes go out on a valid/ready stream, and read bytes come in on a request/data stream. SDA is driven open-drain. SCL is observe-only, and the block never stretches the clock.

## Interface
- TARGET_ADDR, 7'h42, 7-bit bus address this block answers to.
- sync_stages, fixed 2, internal; not a parameter. Listed here only so the SDA/SCL input latency is explicit.
- clk  input  1  system clock; frequency must be at least 8× the SCL frequency.
- rst_n  input  1  reset, asynchronous, active-low.
- scl  input  1  bus clock, observed only.
- sda  inout  1  bus data, open-drain: driven 0 or released to z, never driven 1.
- rx_valid  output  1  one-cycle pulse; a write byte is available on rx_data.
- rx_data  output  8  last received write byte, MSB first on the bus.
- rx_ready  input  1  sampled at the 8th SCL rise of a write byte. 0 makes the target NACK that byte.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- tx_data  input  8  read byte; sampled 2 clk after tx_req.
- tx_valid  input  1  sampled with tx_data. 0 makes the target send 8'hFF.
- busy  output  1  high from address match until STOP or a mismatched repeated START.

## Operation
- Input path: scl and sda each pass through 2 flops, then a third flop for edge detection.
  - START: synced sda falls while synced scl is 1.
  - STOP: synced sda rises while synced scl is 1.
- START or repeated START in any state sets bit_cnt=7, clears the shift register, releases sda, and goes to ADDR.
- STOP in any state releases sda and goes to IDLE.
- States:
  - IDLE: sda released, busy=0.
  - ADDR: shift sda on each scl rise; 8 bits = 7-bit address plus R/W.
    - Match: go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP; sda stays released and busy stays 0.
  - ADDR_ACK: drive sda=0 from the first scl fall after bit 0 until the next scl fall; busy=1.
    - R/W=0: go to RX_BYTE.
    - R/W=1: pulse tx_req at entry, then load tx_data, or 8'hFF if !tx_valid, into the shifter. Next state is TX_BYTE.
  - RX_BYTE: sample 8 bits on scl rises.
    - After the 8th rise: rx_data <= shifter.
    - rx_ready=1: pulse rx_valid the same cycle, then go to RX_ACK with ACK.
    - rx_ready=0: no rx_valid; go to RX_ACK with NACK.
  - RX_ACK: drive sda=0 for ACK, or release for NACK, from scl fall until the next scl fall.
    - After ACK: go to RX_BYTE.
    - After NACK: go to WAIT_STOP.
  - TX_BYTE: present the shifter MSB on sda.
    - sda is updated 1 clk after each synced scl fall: a 0 bit drives low, a 1 bit releases.
    - After 8 bits, release sda and go to TX_ACK.
  - TX_ACK: sample master ACK on scl rise.
    - ACK (0): pulse tx_req, reload the shifter, go to TX_BYTE.
    - NACK (1): go to WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- Bit counter: 3 bits, counts down 7→0, and reloads 7 at every byte boundary.
- Simultaneous events:
  - START or STOP detection has priority over any data-bit sample in the same cycle.
  - A STOP mid-byte discards the partial byte with no rx_valid.
- Reset mid-transfer: state=IDLE and sda released immediately (asynchronous). The bus transaction is abandoned; the master sees NACK or a float.

## Timing
- Reset values: sda=z, rx_valid=0, rx_data=8'h00, tx_req=0, busy=0.
- Pin to internal edge: 3 clk latency.
- sda update: 1 clk after the synced scl-fall detect, i.e. 4 clk after the pin edge. Data hold is therefore ≥4 clk, which requires clk ≥ 8×SCL.
- rx_valid: 1 clk after the synced 8th rise of a byte.
- tx_req to tx_data sample: exactly 2 clk.
- Back-to-back START/STOP: the block must accept events 2 clk apart.

## Test plan
- Write to 0x42 of 0xA5, 0x3C, then STOP, rx_ready=1 → address ACK, two rx_valid pulses with rx_data 0xA5 then 0x3C, both bytes ACKed, busy returns to 0 after STOP.
- Write to 0x43 of 0x11 → sda never driven, no rx_valid, busy stays 0.
- Read from 0x42, tx_data 0x5A then 0xC3, master ACK then NACK → bus bits 0x5A, 0xC3; two tx_req pulses; WAIT_STOP after NACK.
- Write 0x42 of 0x77 with rx_ready=0 → NACK on the data bit, no rx_valid, WAIT_STOP.
- Write 0x42, then 3 data bits, then repeated START and read 0x42 with tx_valid=0 → partial byte dropped, address re-ACKed, 0xFF sent.
- Assert rst_n=0 while driving a TX 0 bit → sda released within 0 clk; all outputs at reset values; the next START at 0x42 is ACKed normally.

Source files
------------

// File: rtl/i2c_target_if.sv
// Byte-stream side of the I2C target: write bytes out on valid/ready, read bytes in on request/data.
// The target drives the slave modport; the local host/consumer uses master.
interface i2c_target_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;

    modport slave (
        output rx_valid, rx_data, tx_req, busy,
        input  rx_ready, tx_data, tx_valid
    );

    modport master (
        input  rx_valid, rx_data, tx_req, busy,
        output rx_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/i2c_target.sv
// Single-address I2C target, oversampling SDA/SCL on clk; open-drain SDA, never stretches SCL.
// Write bytes leave on rx_valid/rx_data, read bytes are requested with tx_req.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl,
    inout  wire           sda,
    i2c_target_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_e;

    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       sda_oe_q, sda_oe_d;
    logic       phase_q, phase_d;
    logic       ack_q, ack_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       tx_req_q, tx_req_d;
    logic       load_q, load_d;

    logic scl_s, scl_p, sda_s, sda_p;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_comb begin
        scl_sync_d = {scl_sync_q[1:0], scl};
        sda_sync_d = {sda_sync_q[1:0], sda};
    end

    assign scl_s     = scl_sync_q[1];
    assign scl_p     = scl_sync_q[2];
    assign sda_s     = sda_sync_q[1];
    assign sda_p     = sda_sync_q[2];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_det = scl_s & sda_p & ~sda_s;
    assign stop_det  = scl_s & ~sda_p & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd7;
            shift_q    <= '0;
            sda_oe_q   <= 1'b0;
            phase_q    <= 1'b0;
            ack_q      <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_req_q   <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            phase_q    <= phase_d;
            ack_q      <= ack_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            tx_req_q   <= tx_req_d;
            load_q     <= load_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        phase_d    = phase_q;
        ack_d      = ack_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        tx_req_d   = 1'b0;
        load_d     = tx_req_q;

        // tx_data is taken two cycles after the tx_req pulse
        if (load_q) begin
            shift_d = bus.tx_valid ? bus.tx_data : 8'hFF;
        end

        case (state_q)
            ST_IDLE: begin
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
            end
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd7;
                        if (shift_q[6:0] == TARGET_ADDR) begin
                            state_d  = ST_ADDR_ACK;
                            busy_d   = 1'b1;
                            rw_d     = sda_s;
                            tx_req_d = sda_s;
                            phase_d  = 1'b0;
                        end else begin
                            state_d = ST_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            ST_ADDR_ACK: begin
                // phase 0: wait for the fall ending bit 0; phase 1: hold ACK until the next fall
                if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = 1'b1;
                        phase_d  = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd7;
                        if (rw_q) begin
                            state_d  = ST_TX_BYTE;
                            sda_oe_d = ~shift_q[7];
                        end else begin
                            state_d  = ST_RX_BYTE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
            end
            ST_RX_BYTE: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d  = 3'd7;
                        rx_data_d  = {shift_q[6:0], sda_s};
                        rx_valid_d = bus.rx_ready;
                        ack_d      = bus.rx_ready;
                        phase_d    = 1'b0;
                        state_d    = ST_RX_ACK;
                    end
                end
            end
            ST_RX_ACK: begin
                if (scl_fall) begin
                    if (!phase_q) begin
                        sda_oe_d = ack_q;
                        phase_d  = 1'b1;
                    end else begin
                        sda_oe_d = 1'b0;
                        phase_d  = 1'b0;
                        state_d  = ack_q ? ST_RX_BYTE : ST_WAIT_STOP;
                    end
                end
            end
            ST_TX_BYTE: begin
                // After a master ACK, phase 1 means the MSB is still to be presented
                if (scl_fall) begin
                    if (phase_q) begin
                        phase_d  = 1'b0;
                        sda_oe_d = ~shift_q[7];
                    end else if (bit_cnt_q == 3'd0) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd7;
                        state_d   = ST_TX_ACK;
                    end else begin
                        shift_d   = {shift_q[6:0], 1'b1};
                        sda_oe_d  = ~shift_q[6];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            ST_TX_ACK: begin
                if (scl_rise) begin
                    if (!sda_s) begin
                        tx_req_d = 1'b1;
                        phase_d  = 1'b1;
                        state_d  = ST_TX_BYTE;
                    end else begin
                        state_d = ST_WAIT_STOP;
                    end
                end
            end
            ST_WAIT_STOP: begin
                sda_oe_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                sda_oe_d = 1'b0;
            end
        endcase

        // Bus conditions override anything the state logic did this cycle
        if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd7;
            shift_d    = '0;
            sda_oe_d   = 1'b0;
            phase_d    = 1'b0;
            load_d     = 1'b0;
            tx_req_d   = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end else if (stop_det) begin
            state_d    = ST_IDLE;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            phase_d    = 1'b0;
            load_d     = 1'b0;
            tx_req_d   = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
        end
    end

    assign sda          = sda_oe_q ? 1'b0 : 1'bz;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on a pulled-up SDA line,
// with hand-computed expectations checked by immediate assertions.
module tb_i2c_target;
    localparam int Q = 5;  // quarter SCL period in clk cycles

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic scl_m     = 1'b1;
    logic sda_m_low = 1'b0;
    wire  sda;

    assign sda = sda_m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target_if bus_if ();

    i2c_target #(.TARGET_ADDR(7'h42)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .scl   (scl_m),
        .sda   (sda),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int txreq_cnt = 0;
    logic [7:0] rx_log [$];
    logic drove     = 1'b0;
    logic busy_seen = 1'b0;

    always @(negedge clk) begin
        if (bus_if.rx_valid) rx_log.push_back(bus_if.rx_data);
        if (bus_if.tx_req) txreq_cnt++;
    end

    always @(posedge clk) begin
        if (sda === 1'b0 && !sda_m_low) drove = 1'b1;
        if (bus_if.busy === 1'b1) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic b, output logic rd);
        tick(Q); sda_m_low = ~b;
        tick(Q); scl_m = 1'b1;
        tick(Q); rd = sda;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic m_start();
        tick(Q); sda_m_low = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m_low = 1'b1;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic m_stop();
        tick(Q); sda_m_low = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m_low = 1'b0;
        tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack_rd);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, ack_rd);
    endtask

    task automatic rd_byte(input logic m_ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~m_ack, r);
    endtask

    initial begin
        logic       a;
        logic [7:0] d;

        bus_if.rx_ready = 1'b1;
        bus_if.tx_data  = 8'h00;
        bus_if.tx_valid = 1'b1;

        // reset values
        tick(3);
        check("rst_sda", sda, 1'b1);
        check("rst_rx_valid", bus_if.rx_valid, 1'b0);
        check("rst_rx_data", bus_if.rx_data, 8'h00);
        check("rst_tx_req", bus_if.tx_req, 1'b0);
        check("rst_busy", bus_if.busy, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // write 0xA5, 0x3C to 0x42
        rx_log.delete();
        m_start();
        wr_byte(8'h84, a); check("t1_addr_ack", a, 1'b0);
        check("t1_busy", bus_if.busy, 1'b1);
        wr_byte(8'hA5, a); check("t1_d0_ack", a, 1'b0);
        wr_byte(8'h3C, a); check("t1_d1_ack", a, 1'b0);
        m_stop();
        tick(4);
        check("t1_rx_count", rx_log.size(), 2);
        check("t1_rx0", rx_log[0], 8'hA5);
        check("t1_rx1", rx_log[1], 8'h3C);
        check("t1_busy_after_stop", bus_if.busy, 1'b0);

        // write to non-matching 0x43
        rx_log.delete();
        drove = 1'b0; busy_seen = 1'b0;
        m_start();
        wr_byte(8'h86, a); check("t2_addr_nack", a, 1'b1);
        wr_byte(8'h11, a); check("t2_data_nack", a, 1'b1);
        m_stop();
        tick(4);
        check("t2_rx_count", rx_log.size(), 0);
        check("t2_never_drove", drove, 1'b0);
        check("t2_busy_never", busy_seen, 1'b0);

        // read 0x5A then 0xC3, master ACK then NACK
        txreq_cnt = 0;
        bus_if.tx_data = 8'h5A; bus_if.tx_valid = 1'b1;
        m_start();
        wr_byte(8'h85, a); check("t3_addr_ack", a, 1'b0);
        bus_if.tx_data = 8'hC3;
        rd_byte(1'b1, d); check("t3_rd0", d, 8'h5A);
        rd_byte(1'b0, d); check("t3_rd1", d, 8'hC3);
        check("t3_txreq_count", txreq_cnt, 2);
        check("t3_busy_wait_stop", bus_if.busy, 1'b1);
        drove = 1'b0;
        wr_byte(8'hFF, a); check("t3_quiet_ack", a, 1'b1);
        check("t3_quiet_txreq", txreq_cnt, 2);
        check("t3_quiet_drove", drove, 1'b0);
        m_stop();
        tick(4);
        check("t3_busy_after_stop", bus_if.busy, 1'b0);

        // write 0x77 with rx_ready low
        rx_log.delete();
        bus_if.rx_ready = 1'b0;
        m_start();
        wr_byte(8'h84, a); check("t4_addr_ack", a, 1'b0);
        wr_byte(8'h77, a); check("t4_data_nack", a, 1'b1);
        bus_if.rx_ready = 1'b1;
        wr_byte(8'h55, a); check("t4_wait_stop_nack", a, 1'b1);
        m_stop();
        tick(4);
        check("t4_rx_count", rx_log.size(), 0);

        // partial write, repeated START, read with tx_valid low
        rx_log.delete();
        txreq_cnt = 0;
        bus_if.tx_valid = 1'b0;
        m_start();
        wr_byte(8'h84, a); check("t5_addr_ack", a, 1'b0);
        bit_xfer(1'b1, a); bit_xfer(1'b0, a); bit_xfer(1'b1, a);
        m_start();
        wr_byte(8'h85, a); check("t5_readdr_ack", a, 1'b0);
        rd_byte(1'b0, d); check("t5_rd_ff", d, 8'hFF);
        m_stop();
        tick(4);
        check("t5_rx_count", rx_log.size(), 0);
        check("t5_txreq_count", txreq_cnt, 1);

        // reset while the target drives a 0 data bit
        bus_if.tx_data = 8'h00; bus_if.tx_valid = 1'b1;
        m_start();
        wr_byte(8'h85, a); check("t6_addr_ack", a, 1'b0);
        tick(Q);
        check("t6_tx0_driven", sda, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_sda_release", sda, 1'b1);
        check("t6_rst_rx_valid", bus_if.rx_valid, 1'b0);
        check("t6_rst_rx_data", bus_if.rx_data, 8'h00);
        check("t6_rst_tx_req", bus_if.tx_req, 1'b0);
        check("t6_rst_busy", bus_if.busy, 1'b0);
        tick(3);
        rst_n = 1'b1;
        m_stop();
        rx_log.delete();
        m_start();
        wr_byte(8'h84, a); check("t6_post_addr_ack", a, 1'b0);
        wr_byte(8'h99, a); check("t6_post_data_ack", a, 1'b0);
        m_stop();
        tick(4);
        check("t6_post_rx_count", rx_log.size(), 1);
        if (rx_log.size() > 0) check("t6_post_rx0", rx_log[0], 8'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
